// File: rtl/i2c_target_regif.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : i2c_target_regif
// Brief   : I2C target (7-bit address) bridging bus transfers to a simple
//           register-file port with an auto-incrementing register pointer.
// Rev     : 1.0 - initial release
// ============================================================================
module i2c_target_regif #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [6:0] address,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_REG       = 4'd3;
    localparam logic [3:0] ST_REG_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;
    localparam logic [3:0] ST_WAIT_STOP = 4'd9;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, sda_prev_q;
    logic [3:0]             state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [7:0]             sr_q, sr_d;
    logic                   rw_q, rw_d;
    logic                   sda_oe_q, sda_oe_d;
    logic                   busy_q, busy_d;
    logic [7:0]             reg_addr_q, reg_addr_d;
    logic [7:0]             reg_wdata_q, reg_wdata_d;
    logic                   reg_we_q, reg_we_d;
    logic                   reg_re_q, reg_re_d;
    logic                   load_q, load_d;
    logic                   inc_q, inc_d;

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;
    logic       is_ack_state;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_s      = scl_sync_q[SYNC_STAGES-1];
        sda_s      = sda_sync_q[SYNC_STAGES-1];
        scl_rise   = scl_s & ~scl_prev_q;
        scl_fall   = ~scl_s & scl_prev_q;
        start_det  = scl_s & sda_prev_q & ~sda_s;
        stop_det   = scl_s & ~sda_prev_q & sda_s;
        rx_byte    = {sr_q[6:0], sda_s};
        is_ack_state = (state_q == ST_ADDR_ACK) || (state_q == ST_REG_ACK) ||
                       (state_q == ST_WDATA_ACK);

        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        load_d      = reg_re_q;
        inc_d       = 1'b0;

        // Read data arrives one clk after the strobe; the pointer advances with it.
        if (load_q) begin
            sr_d       = reg_rdata;
            reg_addr_d = reg_addr_q + 8'd1;
        end
        if (inc_q) begin
            reg_addr_d = reg_addr_q + 8'd1;
        end

        if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            cnt_d    = 4'd0;
        end else if (start_det) begin
            state_d  = ST_ADDR;
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
        end else if (is_ack_state) begin
            if (scl_fall && cnt_q == 4'd8) begin
                sda_oe_d = 1'b1;
            end else if (scl_rise && cnt_q == 4'd8) begin
                cnt_d = 4'd9;
                if (state_q == ST_ADDR_ACK && rw_q) begin
                    reg_re_d = 1'b1;
                end
            end else if (scl_fall && cnt_q == 4'd9) begin
                cnt_d = 4'd0;
                if (state_q == ST_ADDR_ACK && rw_q) begin
                    sda_oe_d = ~sr_q[7];
                    state_d  = ST_RDATA;
                end else begin
                    sda_oe_d = 1'b0;
                    state_d  = (state_q == ST_ADDR_ACK) ? ST_REG : ST_WDATA;
                end
            end
        end else begin
            case (state_q)
                ST_ADDR, ST_REG, ST_WDATA: begin
                    if (scl_rise) begin
                        sr_d  = rx_byte;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            if (state_q == ST_ADDR) begin
                                if (sr_q[6:0] == address) begin
                                    state_d = ST_ADDR_ACK;
                                    busy_d  = 1'b1;
                                    rw_d    = sda_s;
                                end else begin
                                    state_d  = ST_WAIT_STOP;
                                    sda_oe_d = 1'b0;
                                    busy_d   = 1'b0;
                                end
                            end else if (state_q == ST_REG) begin
                                reg_addr_d = rx_byte;
                                state_d    = ST_REG_ACK;
                            end else begin
                                reg_we_d    = 1'b1;
                                reg_wdata_d = rx_byte;
                                inc_d       = 1'b1;
                                state_d     = ST_WDATA_ACK;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        sr_d  = {sr_q[6:0], 1'b0};
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            state_d = ST_RDATA_ACK;
                        end
                    end else if (scl_fall) begin
                        sda_oe_d = ~sr_q[7];
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_fall && cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise && cnt_q == 4'd8) begin
                        if (!sda_s) begin
                            reg_re_d = 1'b1;
                            cnt_d    = 4'd9;
                        end else begin
                            state_d  = ST_WAIT_STOP;
                            sda_oe_d = 1'b0;
                        end
                    end else if (scl_fall && cnt_q == 4'd9) begin
                        sda_oe_d = ~sr_q[7];
                        cnt_d    = 4'd0;
                        state_d  = ST_RDATA;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        // Disabled block looks like reset to the bus but keeps the pointer.
        if (!en) begin
            state_d    = ST_IDLE;
            cnt_d      = 4'd0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            reg_we_d   = 1'b0;
            reg_re_d   = 1'b0;
            load_d     = 1'b0;
            inc_d      = 1'b0;
            reg_addr_d = reg_addr_q;
            sr_d       = sr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            sr_q        <= 8'h00;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            load_q      <= 1'b0;
            inc_q       <= 1'b0;
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_prev_q  <= scl_s;
            sda_prev_q  <= sda_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            load_q      <= load_d;
            inc_q       <= inc_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regif.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_i2c_target_regif
// Brief   : Directed I2C transfers against i2c_target_regif; register strobes
//           are checked by a scoreboard monitor, bus responses inline.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_i2c_target_regif;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b1;
    logic [6:0] address = 7'h70;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_oe;
    logic [7:0] reg_addr, reg_wdata;
    logic       reg_we, reg_re, busy;
    logic [7:0] reg_rdata = 8'h00;
    logic [7:0] mem [256];

    wire sda_bus = sda_drv & ~sda_oe;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;
    ev_t exp_q[$];
    ev_t mon_e;

    always #5 clk = ~clk;

    i2c_target_regif #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .address   (address),
        .scl_in    (scl_drv),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    // Register file: read latency of one clk, preloaded while in reset.
    always @(posedge clk) begin
        if (!reset_n) begin
            mem[8'hF1] <= 8'hA5;
            mem[8'h01] <= 8'h5C;
        end
        if (reg_we) mem[reg_addr] <= reg_wdata;
        if (reg_re) reg_rdata <= mem[reg_addr];
    end

    always @(negedge clk) begin
        if (reg_we || reg_re) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL strobe: unexpected we=%0b re=%0b addr=%h wdata=%h",
                         reg_we, reg_re, reg_addr, reg_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (reg_we === reg_re || mon_e.we !== reg_we || mon_e.addr !== reg_addr ||
                    (mon_e.we && mon_e.data !== reg_wdata)) begin
                    n_bad++;
                    $display("FAIL strobe: got we=%0b re=%0b addr=%h wdata=%h, expected we=%0b addr=%h wdata=%h",
                             reg_we, reg_re, reg_addr, reg_wdata, mon_e.we, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_bit(input logic b, output logic s);
        sda_drv = b;
        wait_clk(5);
        scl_drv = 1'b1;
        wait_clk(5);
        s = sda_bus;
        wait_clk(5);
        scl_drv = 1'b0;
        wait_clk(5);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1;
        wait_clk(5);
        scl_drv = 1'b1;
        wait_clk(5);
        sda_drv = 1'b0;
        wait_clk(5);
        scl_drv = 1'b0;
        wait_clk(5);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0;
        wait_clk(5);
        scl_drv = 1'b1;
        wait_clk(5);
        sda_drv = 1'b1;
        wait_clk(10);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        check(name, {31'd0, ~s}, {31'd0, exp_ack});
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic nack, input string name);
        logic       s;
        logic [7:0] d;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(nack, s);
        check(name, {24'd0, d}, {24'd0, exp});
    endtask

    task automatic push_we(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back('{we: 1'b1, addr: a, data: d});
    endtask

    task automatic push_re(input logic [7:0] a);
        exp_q.push_back('{we: 1'b0, addr: a, data: 8'h00});
    endtask

    initial begin
        logic s;
        wait_clk(4);
        check("rst_sda_oe", {31'd0, sda_oe}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_strobes", {30'd0, reg_we, reg_re}, 0);
        check("rst_reg_addr", {24'd0, reg_addr}, 32'h00);
        check("rst_reg_wdata", {24'd0, reg_wdata}, 32'h00);
        reset_n = 1'b1;
        wait_clk(10);

        // Single register write
        i2c_start();
        write_byte(8'hE0, 1'b1, "wr_addr_ack");
        check("wr_busy", {31'd0, busy}, 1);
        write_byte(8'hF0, 1'b1, "wr_ptr_ack");
        push_we(8'hF0, 8'h0F);
        write_byte(8'h0F, 1'b1, "wr_data_ack");
        i2c_stop();
        check("wr_reg_addr", {24'd0, reg_addr}, 32'hF1);
        check("wr_busy_after_stop", {31'd0, busy}, 0);
        check("wr_q_empty", exp_q.size(), 0);

        // Pointer set then two-byte read
        i2c_start();
        write_byte(8'hE0, 1'b1, "rd_set_addr_ack");
        write_byte(8'hF0, 1'b1, "rd_set_ptr_ack");
        i2c_stop();
        check("rd_ptr", {24'd0, reg_addr}, 32'hF0);
        i2c_start();
        push_re(8'hF0);
        push_re(8'hF1);
        write_byte(8'hE1, 1'b1, "rd_addr_ack");
        read_byte(8'h0F, 1'b0, "rd_byte0");
        read_byte(8'hA5, 1'b1, "rd_byte1");
        i2c_stop();
        check("rd_reg_addr", {24'd0, reg_addr}, 32'hF2);
        check("rd_q_empty", exp_q.size(), 0);

        // Address mismatch, then matching address
        i2c_start();
        write_byte(8'hC0, 1'b0, "mis_nack");
        check("mis_busy", {31'd0, busy}, 0);
        i2c_start();
        write_byte(8'hE0, 1'b1, "mis_then_ack");
        i2c_stop();
        check("mis_q_empty", exp_q.size(), 0);

        // Pointer wrap and repeated START into a read
        i2c_start();
        write_byte(8'hE0, 1'b1, "wrap_addr_ack");
        write_byte(8'hFF, 1'b1, "wrap_ptr_ack");
        push_we(8'hFF, 8'h11);
        write_byte(8'h11, 1'b1, "wrap_d0_ack");
        push_we(8'h00, 8'h22);
        write_byte(8'h22, 1'b1, "wrap_d1_ack");
        i2c_start();
        push_re(8'h01);
        write_byte(8'hE1, 1'b1, "wrap_rd_addr_ack");
        read_byte(8'h5C, 1'b1, "wrap_rd_byte");
        i2c_stop();
        check("wrap_reg_addr", {24'd0, reg_addr}, 32'h02);
        check("wrap_q_empty", exp_q.size(), 0);

        // STOP after four data bits
        i2c_start();
        write_byte(8'hE0, 1'b1, "abort_addr_ack");
        write_byte(8'h10, 1'b1, "abort_ptr_ack");
        bus_bit(1'b1, s);
        bus_bit(1'b0, s);
        bus_bit(1'b1, s);
        bus_bit(1'b1, s);
        i2c_stop();
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_reg_addr", {24'd0, reg_addr}, 32'h10);
        check("abort_q_empty", exp_q.size(), 0);

        // Reset pulse while the target drives an ACK
        i2c_start();
        write_byte(8'hE0, 1'b1, "rst_mid_addr_ack");
        for (int i = 7; i >= 0; i--) bus_bit(((8'h33 >> i) & 8'h01) != 8'h00, s);
        check("rst_mid_ack_driven", {31'd0, sda_oe}, 1);
        reset_n = 1'b0;
        wait_clk(1);
        reset_n = 1'b1;
        check("rst_mid_sda_oe", {31'd0, sda_oe}, 0);
        check("rst_mid_reg_addr", {24'd0, reg_addr}, 32'h00);
        check("rst_mid_busy", {31'd0, busy}, 0);
        wait_clk(5);
        scl_drv = 1'b1;
        wait_clk(5);
        sda_drv = 1'b1;
        wait_clk(10);

        // Disabled block ignores START
        en = 1'b0;
        i2c_start();
        write_byte(8'hE0, 1'b0, "en0_nack");
        check("en0_busy", {31'd0, busy}, 0);
        i2c_stop();
        en = 1'b1;
        wait_clk(5);

        // Recovery write after reset and disable
        i2c_start();
        write_byte(8'hE0, 1'b1, "rec_addr_ack");
        write_byte(8'h40, 1'b1, "rec_ptr_ack");
        push_we(8'h40, 8'h99);
        write_byte(8'h99, 1'b1, "rec_data_ack");
        i2c_stop();
        check("rec_reg_addr", {24'd0, reg_addr}, 32'h41);
        check("rec_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
